// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
//   state_t : responder FSM states (IDLE, BUSY, DONE)
//   op_t    : latched access type (OP_RD, OP_WR)
//   DMEM_DEFAULT_DEPTH / DMEM_DEFAULT_WAIT : default parameter values
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int unsigned DMEM_DEFAULT_DEPTH = 256;
    localparam int unsigned DMEM_DEFAULT_WAIT  = 2;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM: synchronous write, combinational read at the
// same index so the responder can register the word on its access edge.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable, commits wdata to mem[idx] at the edge
//   idx   : word index
//   wdata : write data
//   rdata : word currently stored at idx
module dmem_array #(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port responder with programmable wait states. A request
// seen in IDLE is latched, held in BUSY for WAIT_CYCLES extra cycles, then
// completed; DONE pulses for one cycle while stall drops so the pipeline
// advances.
// Optional feature macro: DMEM_ERR_EN -- flags misaligned/out-of-range
// accesses on err (coincident with done) and suppresses them.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   MemRead  : read request
//   MemWrite : write request (wins when both are high)
//   addr     : byte address, word index = addr[AW+1:2]
//   wd       : write data
//   rd       : registered read data, held until the next completed read
//   stall    : hold pipeline registers/PC while high
//   done     : one-cycle completion pulse
//   err      : access fault pulse (tied low without DMEM_ERR_EN)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = DMEM_DEFAULT_DEPTH,
    parameter  int unsigned WAIT_CYCLES = DMEM_DEFAULT_WAIT,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        stall,
    output logic        done,
    output logic        err
);

    state_t      state;
    logic [3:0]  cnt;
    op_t         op_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [31:0] mem_rdata;
    logic        req;
    logic        out_of_range;
    logic        fault;
    logic        access;
    logic        mem_we;

    assign req          = MemRead | MemWrite;
    assign out_of_range = |addr_q[31:AW+2];

`ifdef DMEM_ERR_EN
    logic misaligned;
    assign misaligned = |addr_q[1:0];
    assign fault      = out_of_range | misaligned;
    // addr_q is still held in DONE, so the flag lines up with done.
    assign err        = (state == DONE) && fault;
`else
    logic unused_lsb;
    assign unused_lsb = ^addr_q[1:0];
    assign fault      = out_of_range;
    assign err        = 1'b0;
`endif

    assign access = (state == BUSY) && (cnt == '0);
    assign mem_we = access && (op_q == OP_WR) && !fault;

    // Gated by rst so stall drops immediately on reset even if a request
    // is still being presented.
    assign stall = rst && (((state == IDLE) && req) || (state == BUSY));
    assign done  = (state == DONE);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .idx  (addr_q[AW+1:2]),
        .wdata(wd_q),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= OP_RD;
            addr_q <= '0;
            wd_q   <= '0;
            rd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q   <= MemWrite ? OP_WR : OP_RD;
                        addr_q <= addr;
                        wd_q   <= wd;
                        cnt    <= 4'(WAIT_CYCLES);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (op_q == OP_RD) begin
                            rd <= fault ? '0 : mem_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// completion for each access and checks stall/latency cycle by cycle; a
// separate monitor pops and compares rd/err whenever done is seen.
module tb_data_mem_responder;

    localparam int unsigned W = 2;
`ifdef DMEM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stall;
    logic        done;
    logic        err;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .addr    (addr),
        .wd      (wd),
        .rd      (rd),
        .stall   (stall),
        .done    (done),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    e = sb.pop_front();
                    chk({e.nm, "_rd"}, rd, e.rd);
                    chk({e.nm, "_err"}, {31'd0, err}, {31'd0, e.err});
                end
            end
        end
    end

    // Call just after a rising edge with the DUT in IDLE.
    task automatic do_access(input string nm, input bit r, input bit w,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input bit exp_err);
        int unsigned cyc = 0;
        bit seen = 1'b0;
        sb.push_back('{nm, exp_rd, exp_err});
        MemRead  = r;
        MemWrite = w;
        addr     = a;
        wd       = d;
        while (cyc < 40) begin
            @(negedge clk);
            chk({nm, "_stall"}, {31'd0, stall}, {31'd0, (cyc <= W + 1) ? 1'b1 : 1'b0});
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_latency"}, seen ? cyc : 32'hFFFF_FFFF, W + 2);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        addr     = '0;
        wd       = '0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rd", rd, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_stall", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;

        do_access("wr_10",  0, 1, 32'h10,  32'h12345678, 32'h0,        0);
        do_access("rd_10",  1, 0, 32'h10,  32'h0,        32'h12345678, 0);
        do_access("wr_20",  0, 1, 32'h20,  32'hA5A5A5A5, 32'h12345678, 0);
        do_access("rd_20",  1, 0, 32'h20,  32'h0,        32'hA5A5A5A5, 0);
        do_access("both_30", 1, 1, 32'h30, 32'hCAFEF00D, 32'hA5A5A5A5, 0);
        do_access("rd_30",  1, 0, 32'h30,  32'h0,        32'hCAFEF00D, 0);
        do_access("wr_0",   0, 1, 32'h0,   32'h01010101, 32'hCAFEF00D, 0);
        do_access("wr_3fc", 0, 1, 32'h3FC, 32'h77665544, 32'hCAFEF00D, 0);
        do_access("rd_3fc", 1, 0, 32'h3FC, 32'h0,        32'h77665544, 0);
        do_access("wr_400", 0, 1, 32'h400, 32'h99999999, 32'h77665544, ERR_ON);
        do_access("rd_400", 1, 0, 32'h400, 32'h0,        32'h0,        ERR_ON);
        do_access("rd_0",   1, 0, 32'h0,   32'h0,        32'h01010101, 0);

        do_access("wr_40",  0, 1, 32'h40,  32'h22222222, 32'h01010101, 0);
        do_access("wr_41",  0, 1, 32'h41,  32'h11111111, 32'h01010101, ERR_ON);
        if (ERR_ON) begin
            do_access("rd_40", 1, 0, 32'h40, 32'h0, 32'h22222222, 0);
            do_access("rd_43", 1, 0, 32'h43, 32'h0, 32'h0,        1);
        end else begin
            do_access("rd_40", 1, 0, 32'h40, 32'h0, 32'h11111111, 0);
            do_access("rd_43", 1, 0, 32'h43, 32'h0, 32'h11111111, 0);
        end

        // Reset in the middle of a write: must not commit, outputs clear at once.
        do_access("wr_50",  0, 1, 32'h50,  32'h0BADF00D, rd, 0);
        MemWrite = 1'b1;
        addr     = 32'h50;
        wd       = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_stall", {31'd0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_rd", rd, 32'd0);
        chk("midrst_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_stall", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;
        do_access("rd_50",  1, 0, 32'h50,  32'h0,        32'h0BADF00D, 0);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
